// File: rtl/id_ex_stage_register_pkg.sv
// pipeline_defs: control bundle layout and register constants shared across pipeline stages
package pipeline_defs;
  localparam int CTRL_W = 8;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_ALUSRC = 3;
  localparam int CTRL_REGDST = 4;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/id_ex_stage_register_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk)
    if (!rst_n) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/id_ex_stage_register.sv
// id_ex_stage_register: ID/EX pipeline register with load-use bubble insertion and stall/flush stats
module id_ex_stage_register
  import pipeline_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int CW     = CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ID_Valid,
  input  logic [CW-1:0]     ID_Ctrl,
  input  logic              ID_UsesRt,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic [DATA_W-1:0] ID_PC4,
  input  logic [4:0]        ID_Rs,
  input  logic [4:0]        ID_Rt,
  input  logic [4:0]        ID_Rd,
  input  logic              Flush,
  input  logic              HoldEX,
  output logic              ID_EX_Valid,
  output logic [CW-1:0]     ID_EX_Ctrl,
  output logic              ID_EX_MemRead,
  output logic [DATA_W-1:0] ID_EX_ReadData1,
  output logic [DATA_W-1:0] ID_EX_ReadData2,
  output logic [DATA_W-1:0] ID_EX_Imm,
  output logic [DATA_W-1:0] ID_EX_PC4,
  output logic [4:0]        ID_EX_RegisterRs,
  output logic [4:0]        ID_EX_RegisterRt,
  output logic [4:0]        ID_EX_RegisterRd,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              LoadUseStall,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);
  logic bubble, stall_bubble;
  always_comb begin
    ID_EX_MemRead = ID_EX_Valid & ID_EX_Ctrl[CTRL_MEMREAD];
    LoadUseStall = ID_EX_MemRead & ID_Valid & (ID_EX_RegisterRt != REG_ZERO) &
                   ((ID_EX_RegisterRt == ID_Rs) | (ID_UsesRt & (ID_EX_RegisterRt == ID_Rt)));
    PCWrite = ~(LoadUseStall | HoldEX) | Flush;
    IF_ID_Write = PCWrite;
    stall_bubble = LoadUseStall & ~HoldEX & ~Flush;
    bubble = Flush | stall_bubble;
  end
  // a bubble zeroes every field so the forwarding unit sees Rd=0 and nothing is written
  always_ff @(posedge clk)
    if (!rst_n || bubble) begin
      ID_EX_Valid      <= 1'b0;
      ID_EX_Ctrl       <= '0;
      ID_EX_ReadData1  <= '0;
      ID_EX_ReadData2  <= '0;
      ID_EX_Imm        <= '0;
      ID_EX_PC4        <= '0;
      ID_EX_RegisterRs <= REG_ZERO;
      ID_EX_RegisterRt <= REG_ZERO;
      ID_EX_RegisterRd <= REG_ZERO;
    end else if (!HoldEX) begin
      ID_EX_Valid      <= ID_Valid;
      ID_EX_Ctrl       <= ID_Valid ? ID_Ctrl : '0;
      ID_EX_ReadData1  <= ID_ReadData1;
      ID_EX_ReadData2  <= ID_ReadData2;
      ID_EX_Imm        <= ID_Imm;
      ID_EX_PC4        <= ID_PC4;
      ID_EX_RegisterRs <= ID_Rs;
      ID_EX_RegisterRt <= ID_Rt;
      ID_EX_RegisterRd <= ID_Rd;
    end
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stall_bubble),
    .count(StallCount)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (Flush),
    .count(FlushCount)
  );
endmodule

// File: tb/tb_id_ex_stage_register.sv
// tb_id_ex_stage_register: directed checks of capture, load-use bubbles, flush, hold and saturation
module tb_id_ex_stage_register;
  localparam int DATA_W = 32;
  localparam int CW = 8;
  localparam int CNT_W = 8;
  localparam logic [7:0] C_LW = 8'h0B, C_ADD = 8'h11, C_SW = 8'h0C;
  logic clk = 1'b0, rst_n, ID_Valid, ID_UsesRt, Flush, HoldEX;
  logic [CW-1:0] ID_Ctrl, ID_EX_Ctrl;
  logic [DATA_W-1:0] ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC4;
  logic [DATA_W-1:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PC4;
  logic [4:0] ID_Rs, ID_Rt, ID_Rd, ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd;
  logic ID_EX_Valid, ID_EX_MemRead, PCWrite, IF_ID_Write, LoadUseStall;
  logic [CNT_W-1:0] StallCount, FlushCount;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  id_ex_stage_register #(.DATA_W(DATA_W), .CW(CW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ID_Valid(ID_Valid), .ID_Ctrl(ID_Ctrl), .ID_UsesRt(ID_UsesRt),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm), .ID_PC4(ID_PC4),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .Flush(Flush), .HoldEX(HoldEX),
    .ID_EX_Valid(ID_EX_Valid), .ID_EX_Ctrl(ID_EX_Ctrl), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2),
    .ID_EX_Imm(ID_EX_Imm), .ID_EX_PC4(ID_EX_PC4), .ID_EX_RegisterRs(ID_EX_RegisterRs),
    .ID_EX_RegisterRt(ID_EX_RegisterRt), .ID_EX_RegisterRd(ID_EX_RegisterRd),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .LoadUseStall(LoadUseStall),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_id(input logic v, input logic [7:0] c, input logic ur,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] base);
    ID_Valid = v; ID_Ctrl = c; ID_UsesRt = ur;
    ID_Rs = rs; ID_Rt = rt; ID_Rd = rd;
    ID_ReadData1 = base; ID_ReadData2 = base + 1; ID_Imm = base + 2; ID_PC4 = base + 4;
  endtask
  initial begin
    rst_n = 1'b0;
    Flush = 1'($urandom); HoldEX = 1'($urandom);
    set_id(1'($urandom), 8'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), $urandom);
    tick();
    Flush = 1'($urandom); HoldEX = 1'($urandom);
    set_id(1'($urandom), 8'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), $urandom);
    tick();
    chk("rst_valid", ID_EX_Valid, 0);
    chk("rst_ctrl", ID_EX_Ctrl, 0);
    chk("rst_data", {ID_EX_ReadData1, ID_EX_Imm}, 0);
    chk("rst_regs", {ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd}, 0);
    chk("rst_cnt", {StallCount, FlushCount}, 0);
    chk("rst_stall", LoadUseStall, 0);
    Flush = 1'b0; HoldEX = 1'b0;
    #1;
    chk("rst_pcwrite", {PCWrite, IF_ID_Write}, 2'b11);
    rst_n = 1'b1;
    set_id(1, C_LW, 0, 5'd1, 5'd2, 5'd0, 32'h100);
    tick();
    chk("lw_valid", ID_EX_Valid, 1);
    chk("lw_ctrl", ID_EX_Ctrl, C_LW);
    chk("lw_memread", ID_EX_MemRead, 1);
    chk("lw_rt", ID_EX_RegisterRt, 2);
    chk("lw_data", {ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PC4},
        {32'h100, 32'h101, 32'h102, 32'h104});
    set_id(1, C_ADD, 1, 5'd2, 5'd5, 5'd4, 32'h200);
    #1;
    chk("lu_stall", LoadUseStall, 1);
    chk("lu_pcwrite", {PCWrite, IF_ID_Write}, 2'b00);
    tick();
    chk("lu_bub_valid", ID_EX_Valid, 0);
    chk("lu_bub_ctrl", ID_EX_Ctrl, 0);
    chk("lu_bub_rd", ID_EX_RegisterRd, 0);
    chk("lu_bub_memread", ID_EX_MemRead, 0);
    chk("lu_stallcnt", StallCount, 1);
    chk("lu_cleared", {LoadUseStall, PCWrite}, 2'b01);
    tick();
    chk("add_ctrl", {ID_EX_Valid, ID_EX_Ctrl}, {1'b1, C_ADD});
    chk("add_regs", {ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd}, {5'd2, 5'd5, 5'd4});
    chk("add_data", ID_EX_ReadData1, 32'h200);
    chk("add_stallcnt", StallCount, 1);
    set_id(1, C_LW, 0, 5'd1, 5'd0, 5'd0, 32'h300);
    tick();
    set_id(1, C_ADD, 1, 5'd0, 5'd0, 5'd7, 32'h310);
    #1;
    chk("r0_nostall", LoadUseStall, 0);
    tick();
    chk("r0_capture", {ID_EX_Valid, ID_EX_Ctrl, ID_EX_RegisterRd}, {1'b1, C_ADD, 5'd7});
    set_id(1, C_LW, 0, 5'd1, 5'd3, 5'd0, 32'h320);
    tick();
    set_id(1, C_SW, 0, 5'd4, 5'd3, 5'd0, 32'h330);
    #1;
    chk("sw_nostall", {LoadUseStall, PCWrite}, 2'b01);
    tick();
    chk("sw_capture", {ID_EX_Valid, ID_EX_Ctrl}, {1'b1, C_SW});
    chk("sw_stallcnt", StallCount, 1);
    set_id(0, C_ADD, 1, 5'd9, 5'd9, 5'd9, 32'h340);
    tick();
    chk("invalid_ctrl", {ID_EX_Valid, ID_EX_Ctrl}, 0);
    set_id(1, C_LW, 0, 5'd1, 5'd2, 5'd0, 32'h400);
    tick();
    set_id(1, C_ADD, 1, 5'd2, 5'd5, 5'd4, 32'h410);
    Flush = 1'b1;
    #1;
    chk("fl_stall", LoadUseStall, 1);
    chk("fl_pcwrite", {PCWrite, IF_ID_Write}, 2'b11);
    tick();
    Flush = 1'b0;
    chk("fl_bubble", {ID_EX_Valid, ID_EX_Ctrl, ID_EX_RegisterRd}, 0);
    chk("fl_counts", {StallCount, FlushCount}, {8'd1, 8'd1});
    set_id(1, C_ADD, 1, 5'd7, 5'd8, 5'd9, 32'h500);
    tick();
    HoldEX = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 8'(i + 1), 0, 5'(i), 5'(i + 10), 5'(i + 20), 32'h600 + 32'(i));
      #1;
      chk("hold_pcwrite", {PCWrite, IF_ID_Write}, 2'b00);
      tick();
      chk("hold_frozen", {ID_EX_Valid, ID_EX_Ctrl, ID_EX_RegisterRs, ID_EX_RegisterRt,
          ID_EX_RegisterRd}, {1'b1, C_ADD, 5'd7, 5'd8, 5'd9});
      chk("hold_data", ID_EX_ReadData1, 32'h500);
      chk("hold_counts", {StallCount, FlushCount}, {8'd1, 8'd1});
    end
    HoldEX = 1'b0;
    set_id(1, C_LW, 0, 5'd1, 5'd6, 5'd0, 32'h700);
    tick();
    HoldEX = 1'b1;
    set_id(1, C_ADD, 1, 5'd6, 5'd1, 5'd2, 32'h710);
    #1;
    chk("holdlu_stall", {LoadUseStall, PCWrite}, 2'b10);
    tick();
    chk("holdlu_kept", {ID_EX_Valid, ID_EX_Ctrl}, {1'b1, C_LW});
    chk("holdlu_cnt", StallCount, 1);
    HoldEX = 1'b0;
    tick();
    chk("holdlu_bubble", {ID_EX_Valid, StallCount}, {1'b0, 8'd2});
    set_id(1, C_LW, 0, 5'd6, 5'd6, 5'd0, 32'h800);
    repeat (253) begin
      tick();
      tick();
    end
    chk("sat_reach", StallCount, 8'hFF);
    repeat (20) begin
      tick();
      tick();
    end
    chk("sat_hold", StallCount, 8'hFF);
    chk("sat_flushcnt", FlushCount, 1);
    tick();
    chk("rstmid_stall", LoadUseStall, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("rstmid_state", {ID_EX_Valid, StallCount, FlushCount}, 0);
    chk("rstmid_pcwrite", {LoadUseStall, PCWrite, IF_ID_Write}, 3'b011);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
